spi_master_arbiter: RTL and testbench

Shares one spi_master_driver between NUM_REQ requesters using round-robin arbitration.
- Accepts byte-transfer requests and forwards the granted requester's byte to the driver.
- Sequences the driver's start/busy handshake.
- Returns the received byte to the winning requester with a one-cycle done pulse.
- Sits directly above spi_master_driver; the driver's SPI pins are untouched.

---
 rtl/spi_master_arbiter.sv | 171 +++++++++++++++++
 tb/tb_spi_master_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/spi_master_arbiter.sv
// rtl/spi_master_arbiter.sv - round-robin arbiter sharing one SPI master driver between NUM_REQ requesters
// Optional watchdog abort enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_master_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [NUM_REQ-1:0]     req_bi,
    input  logic [8*NUM_REQ-1:0]   data_in_bi,
    output logic [NUM_REQ-1:0]     grant_bo,
    output logic [NUM_REQ-1:0]     done_bo,
    output logic [NUM_REQ-1:0]     error_bo,
    output logic [7:0]             data_out_bo,
    output logic                   m_start_o,
    output logic [7:0]             m_data_o,
    input  logic                   m_busy_i,
    input  logic [7:0]             m_data_i
);

    localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [LW:0] NR = (LW+1)'(NUM_REQ);

    typedef enum logic [1:0] {IDLE, START, XFER, DONE} state_t;

    state_t             state, state_nxt;
    logic [LW-1:0]      last, last_nxt, sel, idx;
    logic [LW:0]        sum;
    logic               found;
    logic [NUM_REQ-1:0] grant, grant_nxt, done, done_nxt;
    logic [7:0]         m_data, m_data_nxt, rx, rx_nxt;
    logic               start, start_nxt;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [NUM_REQ-1:0] err, err_nxt;
    logic               timeout_hit;
    assign timeout_hit = (cnt == CW'(TIMEOUT_CYCLES - 1));
`endif

    // Search starts just after the last owner so every requester waits at most NUM_REQ-1 transfers.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            sum = {1'b0, last} + (LW+1)'(i);
            if (sum >= NR) begin
                sum = sum - NR;
            end
            idx = sum[LW-1:0];
            if (!found && req_bi[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        last_nxt   = last;
        grant_nxt  = grant;
        done_nxt   = done;
        m_data_nxt = m_data;
        rx_nxt     = rx;
        start_nxt  = start;
`ifdef SPI_ARB_TIMEOUT_EN
        cnt_nxt    = cnt;
        err_nxt    = err;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    grant_nxt  = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel;
                    last_nxt   = sel;
                    m_data_nxt = data_in_bi[{sel, 3'b000} +: 8];
                    start_nxt  = 1'b1;
                    state_nxt  = START;
`ifdef SPI_ARB_TIMEOUT_EN
                    cnt_nxt    = '0;
`endif
                end
            end
            START: begin
`ifdef SPI_ARB_TIMEOUT_EN
                cnt_nxt = cnt + 1'b1;
`endif
                if (m_busy_i) begin
                    start_nxt = 1'b0;
                    state_nxt = XFER;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (timeout_hit) begin
                    start_nxt = 1'b0;
                    err_nxt   = grant;
                    state_nxt = DONE;
                end
`endif
            end
            XFER: begin
`ifdef SPI_ARB_TIMEOUT_EN
                cnt_nxt = cnt + 1'b1;
`endif
                if (!m_busy_i) begin
                    rx_nxt    = m_data_i;
                    done_nxt  = grant;
                    state_nxt = DONE;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (timeout_hit) begin
                    err_nxt   = grant;
                    state_nxt = DONE;
                end
`endif
            end
            DONE: begin
                done_nxt  = '0;
                grant_nxt = '0;
                state_nxt = IDLE;
`ifdef SPI_ARB_TIMEOUT_EN
                err_nxt   = '0;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state  <= IDLE;
            last   <= LW'(NUM_REQ - 1);
            grant  <= '0;
            done   <= '0;
            m_data <= '0;
            rx     <= '0;
            start  <= 1'b0;
        end else begin
            state  <= state_nxt;
            last   <= last_nxt;
            grant  <= grant_nxt;
            done   <= done_nxt;
            m_data <= m_data_nxt;
            rx     <= rx_nxt;
            start  <= start_nxt;
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt <= '0;
            err <= '0;
        end else begin
            cnt <= cnt_nxt;
            err <= err_nxt;
        end
    end
    assign error_bo = err;
`else
    assign error_bo = '0;
`endif

    assign grant_bo    = grant;
    assign done_bo     = done;
    assign data_out_bo = rx;
    assign m_start_o   = start;
    assign m_data_o    = m_data;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb/tb_spi_master_arbiter.sv - vector-table bench for spi_master_arbiter (2 requesters, watchdog 16 when SPI_ARB_TIMEOUT_EN)
module tb_spi_master_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [15:0] din = 16'h0000;
    logic [1:0]  grant, done, error;
    logic [7:0]  dout, m_data;
    logic        m_start;
    logic        busy = 1'b0;
    logic [7:0]  rx = 8'h00;
    logic [22:0] outs;

    int passed = 0;
    int total  = 0;

    spi_master_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_bi(req), .data_in_bi(din),
        .grant_bo(grant), .done_bo(done), .error_bo(error), .data_out_bo(dout),
        .m_start_o(m_start), .m_data_o(m_data), .m_busy_i(busy), .m_data_i(rx)
    );

    always #5 clk = ~clk;

    assign outs = {grant, m_start, done, error, m_data, dout};

    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic [15:0] din;
        logic        busy;
        logic [7:0]  rx;
        logic [22:0] exp;
    } vec_t;

    vec_t tbl[$];
    logic [7:0] cur_md, cur_dout;

    task automatic chk(input string nm, input logic [22:0] got, input logic [22:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s: got {g,s,d,e,md,do}=%h required %h", nm, got, exp);
        else
            passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic push(input logic r, input logic [1:0] rq, input logic [15:0] d, input logic b,
                        input logic [7:0] x, input logic [1:0] eg, input logic es, input logic [1:0] ed,
                        input logic [7:0] emd, input logic [7:0] edo);
        vec_t v;
        v.rst = r; v.req = rq; v.din = d; v.busy = b; v.rx = x;
        v.exp = {eg, es, ed, 2'b00, emd, edo};
        tbl.push_back(v);
    endtask

    task automatic add_idle(input logic r, input logic [1:0] rq);
        if (r) begin
            cur_md = 8'h00;
            cur_dout = 8'h00;
        end
        push(r, rq, 16'h0000, 1'b0, 8'h00, 2'b00, 1'b0, 2'b00, cur_md, cur_dout);
    endtask

    // One transfer: grant cycle, swait START cycles with busy low, xlen XFER cycles, done cycle, DONE exit.
    task automatic add_xfer(input logic [1:0] req_g, input logic [1:0] req_h, input logic [7:0] d0,
                            input logic [7:0] d1, input logic [1:0] who, input int swait,
                            input int xlen, input logic [7:0] x);
        logic [15:0] d, dalt;
        d = {d1, d0};
        dalt = ~d;
        cur_md = (who == 2'b01) ? d0 : d1;
        push(1'b0, req_g, d, 1'b0, 8'h00, who, 1'b1, 2'b00, cur_md, cur_dout);
        for (int i = 0; i < swait; i++)
            push(1'b0, req_h, dalt, 1'b0, 8'h00, who, 1'b1, 2'b00, cur_md, cur_dout);
        push(1'b0, req_h, dalt, 1'b1, 8'h00, who, 1'b0, 2'b00, cur_md, cur_dout);
        for (int i = 1; i < xlen; i++)
            push(1'b0, req_h, dalt, 1'b1, ~x, who, 1'b0, 2'b00, cur_md, cur_dout);
        cur_dout = x;
        push(1'b0, req_h, dalt, 1'b0, x, who, 1'b0, who, cur_md, cur_dout);
        push(1'b0, req_h, dalt, 1'b0, 8'h00, 2'b00, 1'b0, 2'b00, cur_md, cur_dout);
    endtask

    initial begin
        cur_md = 8'h00;
        cur_dout = 8'h00;
        add_idle(1'b1, 2'b00);
        add_xfer(2'b01, 2'b01, 8'hAC, 8'h00, 2'b01, 2, 2, 8'hA5);
        add_idle(1'b0, 2'b00);
        add_idle(1'b1, 2'b00);
        add_xfer(2'b11, 2'b11, 8'h11, 8'h22, 2'b01, 0, 1, 8'h5A);
        add_xfer(2'b10, 2'b10, 8'h11, 8'h22, 2'b10, 0, 1, 8'hC3);
        add_idle(1'b0, 2'b00);
        add_xfer(2'b01, 2'b11, 8'h33, 8'h44, 2'b01, 0, 1, 8'h01);
        add_xfer(2'b11, 2'b11, 8'h33, 8'h44, 2'b10, 0, 1, 8'h02);
        add_xfer(2'b11, 2'b11, 8'h35, 8'h46, 2'b01, 0, 1, 8'h03);
        add_xfer(2'b11, 2'b11, 8'h35, 8'h46, 2'b10, 0, 1, 8'h04);
        add_xfer(2'b11, 2'b11, 8'h37, 8'h48, 2'b01, 0, 1, 8'h05);
        add_xfer(2'b11, 2'b11, 8'h37, 8'h48, 2'b10, 0, 1, 8'h06);
        add_idle(1'b0, 2'b00);
        add_xfer(2'b01, 2'b00, 8'h77, 8'h00, 2'b01, 1, 2, 8'h9E);
        add_idle(1'b0, 2'b00);
        add_idle(1'b0, 2'b00);

        #1;
        rst_n = 1'b0;
        #1;
        chk("reset_async", outs, 23'h0);
        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            req = tbl[i].req; din = tbl[i].din; busy = tbl[i].busy; rx = tbl[i].rx;
            step();
            chk($sformatf("vec%0d", i), outs, tbl[i].exp);
        end

        // Asynchronous reset in the middle of XFER, then a normal grant to requester 1.
        do_reset();
        req = 2'b01; din = 16'h005E; busy = 1'b0;
        step();
        chk("rst_mid_grant", outs, {2'b01, 1'b1, 2'b00, 2'b00, 8'h5E, 8'h00});
        busy = 1'b1;
        step();
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_clear", outs, 23'h0);
        rst_n = 1'b1;
        req = 2'b10; din = 16'h6B00; busy = 1'b0;
        step();
        chk("rst_after_grant", outs, {2'b10, 1'b1, 2'b00, 2'b00, 8'h6B, 8'h00});
        busy = 1'b1;
        step();
        chk("rst_after_xfer", outs, {2'b10, 1'b0, 2'b00, 2'b00, 8'h6B, 8'h00});
        busy = 1'b0; rx = 8'hB4;
        step();
        chk("rst_after_done", outs, {2'b10, 1'b0, 2'b10, 2'b00, 8'h6B, 8'hB4});
        req = 2'b00;
        step();
        chk("rst_after_idle", outs, {2'b00, 1'b0, 2'b00, 2'b00, 8'h6B, 8'hB4});

        // Driver never raises busy.
        do_reset();
        req = 2'b01; din = 16'h00E7; busy = 1'b0;
        step();
        chk("wd_start", outs, {2'b01, 1'b1, 2'b00, 2'b00, 8'hE7, 8'h00});
`ifdef SPI_ARB_TIMEOUT_EN
        for (int k = 1; k < 16; k++) begin
            step();
            chk($sformatf("wd_wait%0d", k), outs, {2'b01, 1'b1, 2'b00, 2'b00, 8'hE7, 8'h00});
        end
        step();
        chk("wd_error", outs, {2'b01, 1'b0, 2'b00, 2'b01, 8'hE7, 8'h00});
        req = 2'b00;
        step();
        chk("wd_exit", outs, {2'b00, 1'b0, 2'b00, 2'b00, 8'hE7, 8'h00});
        step();
        chk("wd_idle", outs, {2'b00, 1'b0, 2'b00, 2'b00, 8'hE7, 8'h00});
`else
        for (int k = 1; k <= 20; k++) begin
            step();
            chk($sformatf("wait%0d", k), outs, {2'b01, 1'b1, 2'b00, 2'b00, 8'hE7, 8'h00});
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
